fp_align_add: RTL and testbench

FP_ALIGN_ADD -- requirements
Module: fp_align_add

---
 rtl/fp_pkg.sv | 13 +
 rtl/fp_align.sv | 53 +++++
 rtl/fp_align_add.sv | 115 +++++++++++
 tb/tb_fp_align_add.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared floating-point constants and operand record for the align/add datapath.
package fp_pkg;

  localparam int FP_M = 10;
  localparam int FP_E = 5;

  typedef struct packed {
    logic            sign;
    logic [FP_E-1:0] exp;
    logic [FP_M-1:0] mant;
  } fp_operand_t;

endpackage

// File: rtl/fp_align.sv
// Stage-1 combinational datapath: orders operands by magnitude, derives the effective
// operation and result sign, and right-shifts the smaller mantissa into alignment.
module fp_align import fp_pkg::*; #(
  parameter int M = FP_M,
  parameter int E = FP_E
) (
  input  logic         a_sign,
  input  logic [E-1:0] a_exp,
  input  logic [M-1:0] a_mant,
  input  logic         b_sign,
  input  logic [E-1:0] b_exp,
  input  logic [M-1:0] b_mant,
  input  logic         sub,
  output logic [E-1:0] large_exp,
  output logic [M-1:0] large_mant,
  output logic [M-1:0] small_mant,
  output logic         eff_sub,
  output logic         sign
);

  logic         b_eff_sign;
  logic         a_larger;
  logic [E-1:0] small_exp;
  logic [E-1:0] exp_diff;
  logic [M-1:0] small_raw;

  // NOTE: every output of this block gets a value on every path, so no latch can form.
  always_comb begin
    b_eff_sign = b_sign ^ sub;
    eff_sub    = a_sign ^ b_eff_sign;
    // Ties in magnitude keep A as the larger operand.
    a_larger   = (a_exp > b_exp) || ((a_exp == b_exp) && (a_mant >= b_mant));

    if (a_larger) begin
      large_exp  = a_exp;
      large_mant = a_mant;
      small_exp  = b_exp;
      small_raw  = b_mant;
      sign       = a_sign;
    end else begin
      large_exp  = b_exp;
      large_mant = b_mant;
      small_exp  = a_exp;
      small_raw  = a_mant;
      sign       = b_eff_sign;
    end

    exp_diff = large_exp - small_exp;
    if (int'(exp_diff) >= M) small_mant = '0;
    else                     small_mant = small_raw >> exp_diff;
  end

endmodule

// File: rtl/fp_align_add.sv
// Two-stage valid/ready pipeline: aligned operands registered in stage 1, raw
// sum/difference registered in stage 2 for the downstream normalizing shifter.
module fp_align_add import fp_pkg::*; #(
  parameter int M = FP_M,
  parameter int E = FP_E
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         a_sign,
  input  logic [E-1:0] a_exp,
  input  logic [M-1:0] a_mant,
  input  logic         b_sign,
  input  logic [E-1:0] b_exp,
  input  logic [M-1:0] b_mant,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         sign,
  output logic [E-1:0] exp,
  output logic [M-1:0] mantissa,
  output logic         mantissa_overflow
);

  logic         al_eff_sub, al_sign;
  logic [E-1:0] al_exp;
  logic [M-1:0] al_large, al_small;

  fp_align #(.M(M), .E(E)) u_align (
    .a_sign     (a_sign),
    .a_exp      (a_exp),
    .a_mant     (a_mant),
    .b_sign     (b_sign),
    .b_exp      (b_exp),
    .b_mant     (b_mant),
    .sub        (sub),
    .large_exp  (al_exp),
    .large_mant (al_large),
    .small_mant (al_small),
    .eff_sub    (al_eff_sub),
    .sign       (al_sign)
  );

  logic         s1_valid, s1_eff_sub, s1_sign;
  logic [E-1:0] s1_exp;
  logic [M-1:0] s1_large, s1_small;
  logic         s2_load, s1_adv, s1_load;

  always_comb begin
    s2_load  = !out_valid || out_ready;
    s1_adv   = s1_valid && s2_load;
    in_ready = !s1_valid || s1_adv;
    s1_load  = in_valid && in_ready;
  end

  logic [M:0]   sum;
  logic [M-1:0] nxt_mant;
  logic         nxt_ovf, nxt_sign;

  always_comb begin
    sum = {1'b0, s1_large} + {1'b0, s1_small};
    if (s1_eff_sub) begin
      nxt_mant = s1_large - s1_small;
      nxt_ovf  = 1'b0;
      // An exact cancellation is reported as +0.
      nxt_sign = (s1_large == s1_small) ? 1'b0 : s1_sign;
    end else begin
      nxt_mant = sum[M-1:0];
      nxt_ovf  = sum[M];
      nxt_sign = s1_sign;
    end
  end

  // NOTE: data registers are reset as well as valid bits so the outputs read as zero out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid   <= 1'b0;
      s1_eff_sub <= 1'b0;
      s1_sign    <= 1'b0;
      s1_exp     <= '0;
      s1_large   <= '0;
      s1_small   <= '0;
    end else begin
      // NOTE: non-blocking assignments so both stages see pre-edge values of each other.
      if (in_ready) s1_valid <= in_valid;
      if (s1_load) begin
        s1_eff_sub <= al_eff_sub;
        s1_sign    <= al_sign;
        s1_exp     <= al_exp;
        s1_large   <= al_large;
        s1_small   <= al_small;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid         <= 1'b0;
      sign              <= 1'b0;
      exp               <= '0;
      mantissa          <= '0;
      mantissa_overflow <= 1'b0;
    end else begin
      if (s2_load) out_valid <= s1_valid;
      if (s1_adv) begin
        sign              <= nxt_sign;
        exp               <= s1_exp;
        mantissa          <= nxt_mant;
        mantissa_overflow <= nxt_ovf;
      end
    end
  end

endmodule

// File: tb/tb_fp_align_add.sv
// Directed, table-driven bench for fp_align_add: single-shot latency, streaming with
// back-pressure, stall fill/hold, and reset with both stages occupied.
module tb_fp_align_add;
  import fp_pkg::*;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid, in_ready;
  logic            a_sign, b_sign, sub;
  logic [FP_E-1:0] a_exp, b_exp;
  logic [FP_M-1:0] a_mant, b_mant;
  logic            out_valid, out_ready;
  logic            sign;
  logic [FP_E-1:0] exp;
  logic [FP_M-1:0] mantissa;
  logic            mantissa_overflow;

  fp_align_add #(.M(FP_M), .E(FP_E)) dut (
    .clk               (clk),
    .reset             (reset),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .a_sign            (a_sign),
    .a_exp             (a_exp),
    .a_mant            (a_mant),
    .b_sign            (b_sign),
    .b_exp             (b_exp),
    .b_mant            (b_mant),
    .sub               (sub),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .sign              (sign),
    .exp               (exp),
    .mantissa          (mantissa),
    .mantissa_overflow (mantissa_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    fp_operand_t     a;
    fp_operand_t     b;
    logic            sub;
    logic            sign;
    logic [FP_E-1:0] exp;
    logic [FP_M-1:0] mant;
    logic            ovf;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic vec_t mk(input logic as, input int ae, input int am,
                              input logic bs, input int be, input int bm, input logic sb,
                              input logic rs, input int re, input int rm, input logic ro);
    vec_t v;
    v.a    = '{as, FP_E'(ae), FP_M'(am)};
    v.b    = '{bs, FP_E'(be), FP_M'(bm)};
    v.sub  = sb;
    v.sign = rs;
    v.exp  = FP_E'(re);
    v.mant = FP_M'(rm);
    v.ovf  = ro;
    return v;
  endfunction

  task automatic drive(input int i);
    a_sign = vecs[i].a.sign; a_exp = vecs[i].a.exp; a_mant = vecs[i].a.mant;
    b_sign = vecs[i].b.sign; b_exp = vecs[i].b.exp; b_mant = vecs[i].b.mant;
    sub    = vecs[i].sub;
  endtask

  task automatic compare_out(input string pfx, input int i);
    check($sformatf("%s%0d_sign", pfx, i), 32'(sign), 32'(vecs[i].sign));
    check($sformatf("%s%0d_exp", pfx, i), 32'(exp), 32'(vecs[i].exp));
    check($sformatf("%s%0d_mant", pfx, i), 32'(mantissa), 32'(vecs[i].mant));
    check($sformatf("%s%0d_ovf", pfx, i), 32'(mantissa_overflow), 32'(vecs[i].ovf));
  endtask

  // One operation at a time: measures latency and checks the result fields.
  task automatic single(input int i);
    int lat;
    @(negedge clk);
    drive(i);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1 check($sformatf("single%0d_in_ready", i), 32'(in_ready), 32'd1);
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && lat < 10) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check($sformatf("single%0d_latency", i), 32'(lat), 32'd2);
    compare_out("single", i);
  endtask

  // Streams vectors first..last; out_ready is held low for `stall` cycles, then toggles.
  task automatic run_stream(input string pfx, input int first, input int last, input int stall);
    int q[$];
    int idx, got, caps, n, cyc;
    n = last - first + 1;
    idx = first; got = 0; caps = 0;
    for (cyc = 0; cyc < 300 && got < n; cyc++) begin
      @(negedge clk);
      out_ready = (cyc < stall) ? 1'b0 : ((cyc % 3) != 2);
      if (idx <= last) begin
        drive(idx);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid && out_ready) begin
        if (q.size() == 0) check({pfx, "_extra_output"}, 32'd1, 32'd0);
        else compare_out(pfx, q.pop_front());
        got++;
      end
      if (in_valid && in_ready) begin
        q.push_back(idx);
        idx++;
        caps++;
      end
      if (stall > 0 && cyc == stall - 1) begin
        check({pfx, "_captures_while_stalled"}, 32'(caps), 32'd2);
        check({pfx, "_in_ready_while_stalled"}, 32'(in_ready), 32'd0);
        check({pfx, "_out_valid_while_stalled"}, 32'(out_valid), 32'd1);
        compare_out({pfx, "_held"}, first);
      end
    end
    check({pfx, "_result_count"}, 32'(got), 32'(n));
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    int seen;
    //            A sign,exp,mant   B sign,exp,mant   sub  -> sign,exp,mant,ovf
    vecs[0]  = mk(0,  5, 'h200, 0,  5, 'h200, 0, 0,  5, 'h000, 1);
    vecs[1]  = mk(0,  7, 'h200, 0,  5, 'h200, 0, 0,  7, 'h280, 0);
    vecs[2]  = mk(0,  9, 'h300, 0,  9, 'h300, 1, 0,  9, 'h000, 0);
    vecs[3]  = mk(0,  9, 'h300, 0,  9, 'h380, 1, 1,  9, 'h080, 0);
    vecs[4]  = mk(0, 20, 'h3FF, 1,  5, 'h3FF, 0, 0, 20, 'h3FF, 0);
    vecs[5]  = mk(1,  6, 'h300, 0,  4, 'h200, 0, 1,  6, 'h280, 0);
    vecs[6]  = mk(0,  3, 'h200, 0,  6, 'h240, 1, 1,  6, 'h200, 0);
    vecs[7]  = mk(0, 15, 'h3FF, 0,  6, 'h3FF, 0, 0, 15, 'h000, 1);
    vecs[8]  = mk(0, 16, 'h3FF, 0,  6, 'h3FF, 0, 0, 16, 'h3FF, 0);
    vecs[9]  = mk(1,  8, 'h2AA, 1,  8, 'h155, 0, 1,  8, 'h3FF, 0);
    vecs[10] = mk(1,  4, 'h300, 0,  4, 'h300, 0, 0,  4, 'h000, 0);

    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    drive(0);
    #12;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_sign", 32'(sign), 32'd0);
    check("reset_exp", 32'(exp), 32'd0);
    check("reset_mant", 32'(mantissa), 32'd0);
    check("reset_ovf", 32'(mantissa_overflow), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1 check("post_reset_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < NV; i++) single(i);

    run_stream("stream", 0, NV - 1, 0);
    run_stream("stall", 0, 2, 4);

    // Fill both stages, then reset mid-cycle.
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      drive(5 + c);
      in_valid = 1'b1;
    end
    #1;
    check("full_out_valid", 32'(out_valid), 32'd1);
    check("full_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    #1 reset = 1'b0;
    #1;
    check("async_reset_out_valid", 32'(out_valid), 32'd0);
    check("async_reset_mant", 32'(mantissa), 32'd0);
    check("async_reset_exp", 32'(exp), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    out_ready = 1'b1;
    #1 check("release_in_ready", 32'(in_ready), 32'd1);
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("no_stale_after_reset", 32'(seen), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
